au_sequencer: RTL and testbench
===============================

AU_SEQUENCER -- requirements
Module: au_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, sets the number of EXEC cycles allowed for adder settling; legal range 1..15.
REQ-002 CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 CLR  input  1  reset, asynchronous, active-low.
REQ-004 Enter  input  1  one-cycle, already-debounced user advance pulse.
REQ-005 Abort  input  1  one-cycle, already-debounced cancel pulse.
REQ-006 Op  input  1  operation select: 0 = add, 1 = subtract.
REQ-007 Ccout  input  4  datapath flags {Cout, Ovr, Zero, Neg}.
REQ-008 InA  output  1  operand-A register load strobe.
REQ-009 InB  output  1  operand-B register load strobe.
REQ-010 Out  output  1  result register load strobe.
REQ-011 Clear  output  1  datapath register clear strobe, active-high.
REQ-012 Add_Subtract  output  1  operation driven to the adder.
REQ-013 Busy  output  1  high in LD_A, LD_B, EXEC, ST and CLEAR.
REQ-014 Done  output  1  high in DONE.
REQ-015 State  output  3  current state encoding.
REQ-016 Flags  output  4  latched datapath flags; see Configuration.

Function
REQ-017 The FSM states and State encodings SHALL be: IDLE=0, LD_A=1, WAIT_B=2, LD_B=3, EXEC=4, ST=5, DONE=6, CLEAR=7.
REQ-018 Transitions SHALL be:
- IDLE to LD_A on Enter.
- LD_A to WAIT_B unconditionally.
- WAIT_B to LD_B on Enter.
- LD_B to EXEC unconditionally.
- EXEC to ST when the settle counter expires.
- ST to DONE unconditionally.
- DONE to CLEAR on Enter.
- CLEAR to IDLE unconditionally.
REQ-019 Abort in any state except IDLE SHALL force the next state to CLEAR; Abort in IDLE is ignored.
REQ-020 Abort SHALL win over a simultaneous Enter.
REQ-021 Enter SHALL be ignored in LD_A, LD_B, EXEC, ST and CLEAR; it is not queued.
REQ-022 Strobe outputs SHALL be decoded from registered state and be glitch-free:
- InA high only in LD_A.
- InB high only in LD_B.
- Out high only in ST.
- Clear high only in CLEAR.
- Each strobe is exactly one cycle wide.
REQ-023 Add_Subtract SHALL capture Op on the cycle the FSM enters LD_B and hold that value until CLEAR.
REQ-024 Add_Subtract SHALL return to 0 in CLEAR.
REQ-025 A 4-bit settle counter SHALL load SETTLE_CYCLES-1 on entry to EXEC and decrement each EXEC cycle; EXEC exits when the counter is 0, so EXEC lasts exactly SETTLE_CYCLES cycles.
REQ-026 Latency from an accepted Enter in WAIT_B (cycle t):
- InB high at t+1.
- EXEC from t+2 through t+1+SETTLE_CYCLES.
- Out high at t+2+SETTLE_CYCLES.
- Done high from t+3+SETTLE_CYCLES.
REQ-027 Ccout SHALL NOT affect state transitions.

Reset
REQ-028 While CLR is low, the block SHALL immediately (asynchronously) enter IDLE.
REQ-029 While CLR is low, all outputs SHALL read: InA=InB=Out=Clear=0, Add_Subtract=0, Busy=0, Done=0, State=0, Flags=0; the settle counter is 0.
REQ-030 Reset asserted mid-operation SHALL abandon the sequence without issuing a Clear strobe.
REQ-031 The first Enter accepted after CLR rises SHALL be the one sampled on the first rising edge with CLR high.

Configuration
REQ-032 Macro AU_SEQ_FLAG_LATCH_EN defined: Flags SHALL capture Ccout at the end of the ST cycle, hold it through DONE, and clear to 0 in CLEAR or on reset.
REQ-033 Macro AU_SEQ_FLAG_LATCH_EN undefined: Flags SHALL be constant 0, no flag register is built, and Ccout is unused.

Verification
REQ-034 Reset then Enter, Enter(Op=1), SETTLE_CYCLES=2 -> InA pulse, InB pulse with Add_Subtract=1, 2 EXEC cycles, Out pulse, State=6, Done=1.
REQ-035 In DONE, Enter -> single-cycle Clear, Add_Subtract=0, State=0 next cycle.
REQ-036 Abort and Enter together in WAIT_B -> CLEAR, then IDLE; no InB pulse.
REQ-037 Enter held high every cycle from IDLE -> at most one strobe per state visit; sequence IDLE,1,2,3,4,4,5,6,7,0 repeats with no double strobes.
REQ-038 CLR driven low during EXEC -> outputs zero immediately, State=0, no Out or Clear pulse.
REQ-039 With AU_SEQ_FLAG_LATCH_EN defined and Ccout=4'b1010 during ST -> Flags=4'b1010 in DONE and 0 after CLEAR; with the macro undefined -> Flags stays 0.

Source files
------------

// File: rtl/au_sequencer.sv
// Operand/execute/store sequencer for a simple add/subtract unit.
// Optional flag latch is built only when AU_SEQ_FLAG_LATCH_EN is defined.
`timescale 1ns/1ps
module au_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       Enter,
  input  logic       Abort,
  input  logic       Op,
  input  logic [3:0] Ccout,
  output logic       InA,
  output logic       InB,
  output logic       Out,
  output logic       Clear,
  output logic       Add_Subtract,
  output logic       Busy,
  output logic       Done,
  output logic [2:0] State,
  output logic [3:0] Flags
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD_A   = 3'd1,
    S_WAIT_B = 3'd2,
    S_LD_B   = 3'd3,
    S_EXEC   = 3'd4,
    S_ST     = 3'd5,
    S_DONE   = 3'd6,
    S_CLEAR  = 3'd7
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_r;
  state_t     state_next_s;
  logic [3:0] cnt_r;
  logic       addsub_r;
  logic       ina_r;
  logic       inb_r;
  logic       out_r;
  logic       clear_r;
  logic       busy_r;
  logic       done_r;

  // State register
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; Abort outranks every other transition except in IDLE
  always_comb begin
    state_next_s = state_r;
    if (Abort && (state_r != S_IDLE)) begin
      state_next_s = S_CLEAR;
    end else begin
      case (state_r)
        S_IDLE:   if (Enter) state_next_s = S_LD_A;   else state_next_s = S_IDLE;
        S_LD_A:   state_next_s = S_WAIT_B;
        S_WAIT_B: if (Enter) state_next_s = S_LD_B;   else state_next_s = S_WAIT_B;
        S_LD_B:   state_next_s = S_EXEC;
        S_EXEC:   if (cnt_r == 4'd0) state_next_s = S_ST; else state_next_s = S_EXEC;
        S_ST:     state_next_s = S_DONE;
        S_DONE:   if (Enter) state_next_s = S_CLEAR;  else state_next_s = S_DONE;
        S_CLEAR:  state_next_s = S_IDLE;
        default:  state_next_s = S_IDLE;
      endcase
    end
  end

  // Settle counter: loaded on the way into EXEC, counts down while there
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      cnt_r <= 4'd0;
    end else if ((state_r == S_LD_B) && (state_next_s == S_EXEC)) begin
      cnt_r <= SETTLE_LOAD;
    end else if ((state_r == S_EXEC) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else if (state_r != S_EXEC) begin
      cnt_r <= 4'd0;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Strobes are flops decoded from the next state, so they track State without glitches
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      ina_r    <= 1'b0;
      inb_r    <= 1'b0;
      out_r    <= 1'b0;
      clear_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      addsub_r <= 1'b0;
    end else begin
      ina_r   <= (state_next_s == S_LD_A);
      inb_r   <= (state_next_s == S_LD_B);
      out_r   <= (state_next_s == S_ST);
      clear_r <= (state_next_s == S_CLEAR);
      busy_r  <= (state_next_s inside {S_LD_A, S_LD_B, S_EXEC, S_ST, S_CLEAR});
      done_r  <= (state_next_s == S_DONE);
      if ((state_next_s == S_LD_B) && (state_r != S_LD_B)) begin
        addsub_r <= Op;
      end else if (state_next_s == S_CLEAR) begin
        addsub_r <= 1'b0;
      end else begin
        addsub_r <= addsub_r;
      end
    end
  end

  assign InA          = ina_r;
  assign InB          = inb_r;
  assign Out          = out_r;
  assign Clear        = clear_r;
  assign Busy         = busy_r;
  assign Done         = done_r;
  assign Add_Subtract = addsub_r;
  assign State        = state_r;

`ifdef AU_SEQ_FLAG_LATCH_EN
  logic [3:0] flags_r;

  // Flags sample the datapath during ST and are wiped when the sequence clears
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      flags_r <= 4'd0;
    end else if (state_next_s == S_CLEAR) begin
      flags_r <= 4'd0;
    end else if (state_r == S_ST) begin
      flags_r <= Ccout;
    end else begin
      flags_r <= flags_r;
    end
  end

  assign Flags = flags_r;
`else
  logic unused_ccout_s;
  assign unused_ccout_s = ^Ccout;
  assign Flags          = 4'd0;
`endif

endmodule

// File: tb/tb_au_sequencer.sv
// Directed bench for au_sequencer with SETTLE_CYCLES = 2.
// Flag expectations follow AU_SEQ_FLAG_LATCH_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_au_sequencer;

  logic       CLK;
  logic       CLR;
  logic       Enter;
  logic       Abort;
  logic       Op;
  logic [3:0] Ccout;
  logic       InA;
  logic       InB;
  logic       Out;
  logic       Clear;
  logic       Add_Subtract;
  logic       Busy;
  logic       Done;
  logic [2:0] State;
  logic [3:0] Flags;

  int checks;
  int failures;
  logic [9:0] obs;
  logic [3:0] flag_exp;

  au_sequencer #(.SETTLE_CYCLES(2)) dut (
    .CLK(CLK), .CLR(CLR), .Enter(Enter), .Abort(Abort), .Op(Op), .Ccout(Ccout),
    .InA(InA), .InB(InB), .Out(Out), .Clear(Clear), .Add_Subtract(Add_Subtract),
    .Busy(Busy), .Done(Done), .State(State), .Flags(Flags)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign obs = {State, InA, InB, Out, Clear, Add_Subtract, Busy, Done};

  // Expected output vector for a given state and operation bit
  function automatic logic [9:0] exp_of(input logic [2:0] st, input logic as_v);
    logic busy_v;
    busy_v = (st == 3'd1) || (st == 3'd3) || (st == 3'd4) || (st == 3'd5) || (st == 3'd7);
    return {st, st == 3'd1, st == 3'd3, st == 3'd5, st == 3'd7, as_v, busy_v, st == 3'd6};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    CLR = 1'b0; Enter = 1'b0; Abort = 1'b0; Op = 1'b0; Ccout = 4'd0;
    #12;
    checks++; if (obs !== 10'd0) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", obs, 10'd0); end
    checks++; if (Flags !== 4'd0) begin failures++; $display("FAIL reset_flags got=%b exp=%b", Flags, 4'd0); end
    tick();
    checks++; if (obs !== 10'd0) begin failures++; $display("FAIL reset_held got=%b exp=%b", obs, 10'd0); end
    CLR = 1'b1;
  endtask

  task automatic test_main();
    Enter = 1'b1; tick(); Enter = 1'b0;
    checks++; if (obs !== exp_of(3'd1, 1'b0)) begin failures++; $display("FAIL main_lda got=%b exp=%b", obs, exp_of(3'd1, 1'b0)); end
    tick();
    checks++; if (obs !== exp_of(3'd2, 1'b0)) begin failures++; $display("FAIL main_waitb got=%b exp=%b", obs, exp_of(3'd2, 1'b0)); end
    tick();
    checks++; if (obs !== exp_of(3'd2, 1'b0)) begin failures++; $display("FAIL main_waitb_hold got=%b exp=%b", obs, exp_of(3'd2, 1'b0)); end
    Enter = 1'b1; Op = 1'b1; tick(); Enter = 1'b0; Op = 1'b0;
    checks++; if (obs !== exp_of(3'd3, 1'b1)) begin failures++; $display("FAIL main_ldb got=%b exp=%b", obs, exp_of(3'd3, 1'b1)); end
    tick();
    checks++; if (obs !== exp_of(3'd4, 1'b1)) begin failures++; $display("FAIL main_exec1 got=%b exp=%b", obs, exp_of(3'd4, 1'b1)); end
    tick();
    checks++; if (obs !== exp_of(3'd4, 1'b1)) begin failures++; $display("FAIL main_exec2 got=%b exp=%b", obs, exp_of(3'd4, 1'b1)); end
    Ccout = 4'b1010; tick();
    checks++; if (obs !== exp_of(3'd5, 1'b1)) begin failures++; $display("FAIL main_st got=%b exp=%b", obs, exp_of(3'd5, 1'b1)); end
    tick(); Ccout = 4'b0101;
    checks++; if (obs !== exp_of(3'd6, 1'b1)) begin failures++; $display("FAIL main_done got=%b exp=%b", obs, exp_of(3'd6, 1'b1)); end
    checks++; if (Flags !== flag_exp) begin failures++; $display("FAIL main_flags got=%b exp=%b", Flags, flag_exp); end
  endtask

  task automatic test_clear();
    tick();
    checks++; if (obs !== exp_of(3'd6, 1'b1)) begin failures++; $display("FAIL clear_done_hold got=%b exp=%b", obs, exp_of(3'd6, 1'b1)); end
    checks++; if (Flags !== flag_exp) begin failures++; $display("FAIL clear_flags_hold got=%b exp=%b", Flags, flag_exp); end
    Enter = 1'b1; tick(); Enter = 1'b0;
    checks++; if (obs !== exp_of(3'd7, 1'b0)) begin failures++; $display("FAIL clear_state got=%b exp=%b", obs, exp_of(3'd7, 1'b0)); end
    checks++; if (Flags !== 4'd0) begin failures++; $display("FAIL clear_flags got=%b exp=%b", Flags, 4'd0); end
    tick();
    checks++; if (obs !== exp_of(3'd0, 1'b0)) begin failures++; $display("FAIL clear_idle got=%b exp=%b", obs, exp_of(3'd0, 1'b0)); end
  endtask

  task automatic test_abort();
    Abort = 1'b1; tick(); Abort = 1'b0;
    checks++; if (obs !== exp_of(3'd0, 1'b0)) begin failures++; $display("FAIL abort_idle_ignored got=%b exp=%b", obs, exp_of(3'd0, 1'b0)); end
    Enter = 1'b1; tick(); Enter = 1'b0; tick();
    checks++; if (obs !== exp_of(3'd2, 1'b0)) begin failures++; $display("FAIL abort_reach_waitb got=%b exp=%b", obs, exp_of(3'd2, 1'b0)); end
    Enter = 1'b1; Abort = 1'b1; Op = 1'b1; tick(); Enter = 1'b0; Abort = 1'b0; Op = 1'b0;
    checks++; if (obs !== exp_of(3'd7, 1'b0)) begin failures++; $display("FAIL abort_wins got=%b exp=%b", obs, exp_of(3'd7, 1'b0)); end
    tick();
    checks++; if (obs !== exp_of(3'd0, 1'b0)) begin failures++; $display("FAIL abort_to_idle got=%b exp=%b", obs, exp_of(3'd0, 1'b0)); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq [0:8];
    logic [2:0] st;
    logic       as_v;
    seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    Enter = 1'b1; Op = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick();
      st   = seq[i % 9];
      as_v = (st == 3'd3) || (st == 3'd4) || (st == 3'd5) || (st == 3'd6);
      checks++;
      if (obs !== exp_of(st, as_v)) begin
        failures++;
        $display("FAIL b2b_step%0d got=%b exp=%b", i, obs, exp_of(st, as_v));
      end
    end
    Enter = 1'b0; Op = 1'b0;
  endtask

  task automatic test_reset_mid();
    Enter = 1'b1; tick(); Enter = 1'b0; tick();
    Enter = 1'b1; tick(); Enter = 1'b0; tick();
    checks++; if (obs !== exp_of(3'd4, 1'b0)) begin failures++; $display("FAIL rmid_in_exec got=%b exp=%b", obs, exp_of(3'd4, 1'b0)); end
    #2; CLR = 1'b0; #1;
    checks++; if (obs !== 10'd0) begin failures++; $display("FAIL rmid_async got=%b exp=%b", obs, 10'd0); end
    tick(); tick();
    checks++; if (obs !== 10'd0) begin failures++; $display("FAIL rmid_held got=%b exp=%b", obs, 10'd0); end
    checks++; if (Flags !== 4'd0) begin failures++; $display("FAIL rmid_flags got=%b exp=%b", Flags, 4'd0); end
    Enter = 1'b1; CLR = 1'b1; tick(); Enter = 1'b0;
    checks++; if (obs !== exp_of(3'd1, 1'b0)) begin failures++; $display("FAIL rmid_first_enter got=%b exp=%b", obs, exp_of(3'd1, 1'b0)); end
    Abort = 1'b1; tick(); Abort = 1'b0;
    checks++; if (obs !== exp_of(3'd7, 1'b0)) begin failures++; $display("FAIL rmid_abort_lda got=%b exp=%b", obs, exp_of(3'd7, 1'b0)); end
    tick();
    checks++; if (obs !== exp_of(3'd0, 1'b0)) begin failures++; $display("FAIL rmid_idle got=%b exp=%b", obs, exp_of(3'd0, 1'b0)); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
`ifdef AU_SEQ_FLAG_LATCH_EN
    flag_exp = 4'b1010;
`else
    flag_exp = 4'b0000;
`endif
    test_reset();
    test_main();
    test_clear();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
